// File: rtl/fir_decim_fifo.sv
// Decimate-by-2^M_LOG2 stage with a first-word-fall-through output FIFO and sticky overflow.
// Optional macro FIR_DECIM_AVG_EN: emit the group average instead of the last sample of each group.
module fir_decim_fifo #(
   parameter int N          = 16,
   parameter int M_LOG2     = 2,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  inValid,
   input  logic [N-1:0]          dataIn,
   input  logic                  outReady,
   input  logic                  clrOvf,
   output logic                  outValid,
   output logic [N-1:0]          dataOut,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow
);

   localparam int M     = 1 << M_LOG2;
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int PH_W  = (M_LOG2 > 0) ? M_LOG2 : 1;
   localparam int LV_W  = DEPTH_LOG2 + 1;

   logic [PH_W-1:0]       r_phase;
   logic [N-1:0]          r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [LV_W-1:0]       r_level;
   logic                  r_valid;
   logic                  r_ovf;

   logic                  w_last;
   logic                  w_produce;
   logic [N-1:0]          w_value;
   logic                  w_full;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_drop;
   logic [LV_W-1:0]       w_level_nxt;

   // Group phase: only valid input cycles count.
   assign w_last    = (r_phase == PH_W'(M - 1));
   assign w_produce = inValid && w_last;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_phase <= '0;
      end else if (inValid) begin
         r_phase <= w_last ? '0 : r_phase + PH_W'(1);
      end
   end

`ifdef FIR_DECIM_AVG_EN
   localparam int ACC_W = N + M_LOG2;

   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] w_sum;

   function automatic logic [N-1:0] f_avg(input logic [ACC_W-1:0] sum);
      logic [ACC_W-1:0] shifted;
      shifted = sum >> M_LOG2;
      return shifted[N-1:0];
   endfunction

   // Phase 0 reloads with the new sample so consecutive groups need no idle cycle.
   assign w_sum   = (r_phase == '0) ? ACC_W'(dataIn) : r_acc + ACC_W'(dataIn);
   assign w_value = f_avg(w_sum);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc <= '0;
      end else if (inValid) begin
         r_acc <= w_sum;
      end
   end
`else
   assign w_value = dataIn;
`endif

   // A full FIFO still accepts a sample when the head is popped in the same cycle.
   assign w_full = (r_level == LV_W'(DEPTH));
   assign w_pop  = r_valid && outReady;
   assign w_push = w_produce && (!w_full || w_pop);
   assign w_drop = w_produce && w_full && !w_pop;

   always_comb begin
      w_level_nxt = r_level;
      if (w_push && !w_pop) begin
         w_level_nxt = r_level + LV_W'(1);
      end else if (!w_push && w_pop) begin
         w_level_nxt = r_level - LV_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_value;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_valid  <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
         end
         r_level <= w_level_nxt;
         r_valid <= (w_level_nxt != '0);
         // A drop in the same cycle as a clear keeps the flag set.
         if (w_drop) begin
            r_ovf <= 1'b1;
         end else if (clrOvf) begin
            r_ovf <= 1'b0;
         end
      end
   end

   assign outValid = r_valid;
   assign dataOut  = r_valid ? r_mem[r_rd_ptr] : '0;
   assign level    = r_level;
   assign overflow = r_ovf;

endmodule
